// File: rtl/alu_mc_pkg.sv
// alu_mc shared package: opcodes, operand
// width encodings and FSM state encoding.
package alu_mc_pkg;

   localparam logic [7:0] LD_I    = 8'h01;
   localparam logic [7:0] LDN_I   = 8'h02;
   localparam logic [7:0] LDC_I   = 8'h03;
   localparam logic [7:0] AND_I   = 8'h04;
   localparam logic [7:0] ANDN_I  = 8'h05;
   localparam logic [7:0] ANDC_I  = 8'h06;
   localparam logic [7:0] OR_I    = 8'h07;
   localparam logic [7:0] ORN_I   = 8'h08;
   localparam logic [7:0] ORC_I   = 8'h09;
   localparam logic [7:0] XOR_I   = 8'h0A;
   localparam logic [7:0] XORN_I  = 8'h0B;
   localparam logic [7:0] XORC_I  = 8'h0C;
   localparam logic [7:0] ST_I    = 8'h10;
   localparam logic [7:0] STN_I   = 8'h11;
   localparam logic [7:0] S_I     = 8'h12;
   localparam logic [7:0] R_I     = 8'h13;
   localparam logic [7:0] RTRIG_I = 8'h14;
   localparam logic [7:0] FTRIG_I = 8'h15;
   localparam logic [7:0] NOT_I   = 8'h16;
   localparam logic [7:0] EQU_I   = 8'h17;
   localparam logic [7:0] ADD_I   = 8'h20;
   localparam logic [7:0] SUB_I   = 8'h21;
   localparam logic [7:0] MUL_I   = 8'h22;
   localparam logic [7:0] DIV_I   = 8'h23;
   localparam logic [7:0] MOD_I   = 8'h24;
   localparam logic [7:0] NE_I    = 8'h30;
   localparam logic [7:0] GT_I    = 8'h31;
   localparam logic [7:0] GE_I    = 8'h32;
   localparam logic [7:0] LT_I    = 8'h33;
   localparam logic [7:0] LE_I    = 8'h34;

   localparam logic [1:0] DM_BIT   = 2'b00;
   localparam logic [1:0] DM_BYTE  = 2'b01;
   localparam logic [1:0] DM_WORD  = 2'b10;
   localparam logic [1:0] DM_DWORD = 2'b11;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_EXEC,
      ST_MUL,
      ST_DIV,
      ST_DONE
   } state_t;

endpackage

// File: rtl/alu_mc_seqdiv.sv
// alu_mc iterative shift engine: shift-add MUL,
// restoring DIV when ALU_MC_DIV_EN is defined.
module alu_mc_seqdiv #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic         step,
   input  logic         op_div,
   input  logic [W-1:0] opa,
   input  logic [W-1:0] opb,
   output logic         last,
   output logic [W-1:0] hi_nxt,
   output logic [W-1:0] lo_nxt
);

   localparam int CW = $clog2(W) + 1;

   logic [W-1:0]  hi_q;
   logic [W-1:0]  lo_q;
   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;
   logic [W:0]    sum;
`ifdef ALU_MC_DIV_EN
   logic [W:0]    sh;
`else
   logic          unused_div;
   assign unused_div = op_div;
`endif

   assign last = step && (cnt_q == CW'(1));

   // One iteration per step; hi/lo hold product or rem/quotient
   always_comb begin
      hi_nxt = hi_q;
      lo_nxt = lo_q;
      cnt_d  = cnt_q;
      sum    = '0;
`ifdef ALU_MC_DIV_EN
      sh     = '0;
`endif
      if (load) begin
         hi_nxt = '0;
         lo_nxt = opa;
         cnt_d  = CW'(W);
      end else if (step && cnt_q != '0) begin
         cnt_d = cnt_q - 1'b1;
`ifdef ALU_MC_DIV_EN
         if (op_div) begin
            sh = {hi_q, lo_q[W-1]};
            if (sh >= {1'b0, opb}) begin
               sh     = sh - {1'b0, opb};
               lo_nxt = {lo_q[W-2:0], 1'b1};
            end else begin
               lo_nxt = {lo_q[W-2:0], 1'b0};
            end
            hi_nxt = sh[W-1:0];
         end else
`endif
         begin
            sum = {1'b0, hi_q} +
                  (lo_q[0] ? {1'b0, opb} : '0);
            hi_nxt = sum[W:1];
            lo_nxt = {sum[0], lo_q[W-1:1]};
         end
      end
   end

   // Engine state registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hi_q  <= '0;
         lo_q  <= '0;
         cnt_q <= '0;
      end else begin
         hi_q  <= hi_nxt;
         lo_q  <= lo_nxt;
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/alu_mc.sv
// alu_mc multi-cycle ALU top; DIV/MOD engine
// enabled by macro ALU_MC_DIV_EN.
module alu_mc
   import alu_mc_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int OPC_W  = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   output logic              ready,
   input  logic [OPC_W-1:0]  instr_code,
   input  logic [1:0]        dm_type,
   input  logic              sgn,
   input  logic [DATA_W-1:0] cr_in,
   input  logic [DATA_W-1:0] dm_in,
   input  logic [DATA_W-1:0] pm_const,
   output logic              done,
   output logic [DATA_W-1:0] alu_out_cr,
   output logic [DATA_W-1:0] alu_out_dm,
   output logic              cr_we,
   output logic              dm_we,
   output logic              ovf,
   output logic              div0
);

   localparam int W = DATA_W;

   state_t           state_q, state_d;
   logic [OPC_W-1:0] op_q, op_d;
   logic [1:0]       dmt_q, dmt_d;
   logic             sgn_q, sgn_d;
   logic             ld_q, ld_d;
   logic [W-1:0]     cr_q, cr_d, dm_q, dm_d;
   logic [W-1:0]     pm_q, pm_d;
   logic [W-1:0]     rcr_q, rcr_d, rdm_q, rdm_d;
   logic             done_q, done_d;
   logic             crwe_q, crwe_d;
   logic             dmwe_q, dmwe_d;
   logic             ovf_q, ovf_d;
   logic             dz_q, dz_d;

   logic [W-1:0] m, sb, a, b, p, ax, bx;
   logic [W:0]   sum, dif;
   logic [W-1:0] ex_cr, ex_dm, fin_cr;
   logic         ex_crwe, ex_dmwe, ex_ovf, ex_dz;
   logic         fin_ovf;
   logic         busy, eng_last, is_mul, div_go;
   logic [W-1:0] eng_hi, eng_lo;

   assign ready      = (state_q == ST_IDLE);
   assign done       = done_q;
   assign alu_out_cr = rcr_q;
   assign alu_out_dm = rdm_q;
   assign cr_we      = crwe_q;
   assign dm_we      = dmwe_q;
   assign ovf        = ovf_q;
   assign div0       = dz_q;

   assign is_mul = (instr_code == OPC_W'(MUL_I));
   assign busy   = (state_q == ST_MUL) ||
                   (state_q == ST_DIV);

`ifdef ALU_MC_DIV_EN
   logic is_div, dz_in;
   assign is_div = (instr_code == OPC_W'(DIV_I)) ||
                   (instr_code == OPC_W'(MOD_I));
   // Zero divisor at accept takes the short path
   always_comb begin
      unique case (dm_type)
         DM_BIT:  dz_in = (dm_in[0] == 1'b0);
         DM_BYTE: dz_in = (dm_in[7:0] == 8'h0);
         DM_WORD: dz_in = (dm_in[15:0] == 16'h0);
         default: dz_in = (dm_in == '0);
      endcase
   end
   assign div_go = is_div && !dz_in;
`else
   assign div_go = 1'b0;
`endif

   // Width mask and sign-bit select for operands
   always_comb begin
      unique case (dmt_q)
         DM_BIT: begin
            m  = W'(1);
            sb = '0;
         end
         DM_BYTE: begin
            m  = W'(8'hFF);
            sb = W'(8'h80);
         end
         DM_WORD: begin
            m  = W'(16'hFFFF);
            sb = W'(16'h8000);
         end
         default: begin
            m  = '1;
            sb = {1'b1, {(W-1){1'b0}}};
         end
      endcase
      if (!sgn_q) sb = '0;
   end

   assign a   = cr_q & m;
   assign b   = dm_q & m;
   assign p   = pm_q & m;
   assign ax  = a ^ sb;
   assign bx  = b ^ sb;
   assign sum = {1'b0, a} + {1'b0, b};
   assign dif = {1'b0, a} - {1'b0, b};

   // Single-cycle operations evaluated in EXEC
   always_comb begin
      ex_cr   = '0;
      ex_dm   = '0;
      ex_crwe = 1'b0;
      ex_dmwe = 1'b0;
      ex_ovf  = 1'b0;
      ex_dz   = 1'b0;
      case (op_q)
         OPC_W'(LD_I):   begin ex_cr = b;  ex_crwe = 1'b1; end
         OPC_W'(LDN_I):  begin ex_cr = ~b & m; ex_crwe = 1'b1; end
         OPC_W'(LDC_I):  begin ex_cr = p;  ex_crwe = 1'b1; end
         OPC_W'(AND_I):  begin ex_cr = a & b; ex_crwe = 1'b1; end
         OPC_W'(ANDN_I): begin ex_cr = a & ~b; ex_crwe = 1'b1; end
         OPC_W'(ANDC_I): begin ex_cr = a & p; ex_crwe = 1'b1; end
         OPC_W'(OR_I):   begin ex_cr = a | b; ex_crwe = 1'b1; end
         OPC_W'(ORN_I):  begin ex_cr = (a | ~b) & m; ex_crwe = 1'b1; end
         OPC_W'(ORC_I):  begin ex_cr = a | p; ex_crwe = 1'b1; end
         OPC_W'(XOR_I):  begin ex_cr = a ^ b; ex_crwe = 1'b1; end
         OPC_W'(XORN_I): begin ex_cr = (a ^ ~b) & m; ex_crwe = 1'b1; end
         OPC_W'(XORC_I): begin ex_cr = a ^ p; ex_crwe = 1'b1; end
         OPC_W'(ST_I):   begin ex_cr = a; ex_dm = a; ex_dmwe = 1'b1; end
         OPC_W'(STN_I):  begin ex_cr = a; ex_dm = ~a & m; ex_dmwe = 1'b1; end
         OPC_W'(S_I): begin
            ex_cr   = a;
            ex_dm   = a[0] ? W'(1) : b;
            ex_dmwe = 1'b1;
         end
         OPC_W'(R_I): begin
            ex_cr   = a;
            ex_dm   = a[0] ? '0 : b;
            ex_dmwe = 1'b1;
         end
         OPC_W'(RTRIG_I): begin
            ex_cr   = W'(a[0] & ~b[0]);
            ex_dm   = W'(a[0]);
            ex_crwe = 1'b1;
            ex_dmwe = 1'b1;
         end
         OPC_W'(FTRIG_I): begin
            ex_cr   = W'(~a[0] & b[0]);
            ex_dm   = W'(a[0]);
            ex_crwe = 1'b1;
            ex_dmwe = 1'b1;
         end
         OPC_W'(NOT_I): begin ex_cr = ~a & m; ex_crwe = 1'b1; end
         OPC_W'(EQU_I): begin ex_cr = W'(a == b); ex_crwe = 1'b1; end
         OPC_W'(ADD_I): begin
            ex_cr   = sum[W-1:0] & m;
            ex_ovf  = |(sum & ~{1'b0, m});
            ex_crwe = 1'b1;
         end
         OPC_W'(SUB_I): begin
            ex_cr   = dif[W-1:0] & m;
            ex_ovf  = (a < b);
            ex_crwe = 1'b1;
         end
         OPC_W'(NE_I): begin ex_cr = W'(a != b); ex_crwe = 1'b1; end
         OPC_W'(GT_I): begin ex_cr = W'(ax > bx); ex_crwe = 1'b1; end
         OPC_W'(GE_I): begin ex_cr = W'(ax >= bx); ex_crwe = 1'b1; end
         OPC_W'(LT_I): begin ex_cr = W'(ax < bx); ex_crwe = 1'b1; end
         OPC_W'(LE_I): begin ex_cr = W'(ax <= bx); ex_crwe = 1'b1; end
         OPC_W'(DIV_I), OPC_W'(MOD_I): ex_dz = 1'b1;
         default: ;
      endcase
   end

   // Final MUL/DIV result from the engine's last step
   always_comb begin
      fin_cr  = eng_lo & m;
      fin_ovf = 1'b0;
      if (state_q == ST_DIV) begin
         if (op_q == OPC_W'(MOD_I)) fin_cr = eng_hi & m;
      end else begin
         fin_ovf = (|eng_hi) | (|(eng_lo & ~m));
      end
   end

   alu_mc_seqdiv #(.W(W)) u_seq (
      .clk    (clk),
      .rst_n  (rst_n),
      .load   (busy && ld_q),
      .step   (busy && !ld_q),
      .op_div (state_q == ST_DIV),
      .opa    (a),
      .opb    (b),
      .last   (eng_last),
      .hi_nxt (eng_hi),
      .lo_nxt (eng_lo)
   );

   // FSM next state, operand capture and result staging
   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      dmt_d   = dmt_q;
      sgn_d   = sgn_q;
      ld_d    = ld_q;
      cr_d    = cr_q;
      dm_d    = dm_q;
      pm_d    = pm_q;
      rcr_d   = rcr_q;
      rdm_d   = rdm_q;
      done_d  = 1'b0;
      crwe_d  = 1'b0;
      dmwe_d  = 1'b0;
      ovf_d   = 1'b0;
      dz_d    = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (start) begin
               op_d  = instr_code;
               dmt_d = dm_type;
               sgn_d = sgn && (dm_type != DM_BIT);
               cr_d  = cr_in;
               dm_d  = dm_in;
               pm_d  = pm_const;
               ld_d  = 1'b1;
               if (is_mul)      state_d = ST_MUL;
               else if (div_go) state_d = ST_DIV;
               else             state_d = ST_EXEC;
            end
         end
         ST_EXEC: begin
            state_d = ST_DONE;
            rcr_d   = ex_cr;
            rdm_d   = ex_dm;
            crwe_d  = ex_crwe;
            dmwe_d  = ex_dmwe;
            ovf_d   = ex_ovf;
            dz_d    = ex_dz;
            done_d  = 1'b1;
         end
         ST_MUL, ST_DIV: begin
            ld_d = 1'b0;
            if (eng_last) begin
               state_d = ST_DONE;
               rcr_d   = fin_cr;
               rdm_d   = '0;
               crwe_d  = 1'b1;
               ovf_d   = fin_ovf;
               done_d  = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         op_q    <= '0;
         dmt_q   <= '0;
         sgn_q   <= 1'b0;
         ld_q    <= 1'b0;
         cr_q    <= '0;
         dm_q    <= '0;
         pm_q    <= '0;
         rcr_q   <= '0;
         rdm_q   <= '0;
         done_q  <= 1'b0;
         crwe_q  <= 1'b0;
         dmwe_q  <= 1'b0;
         ovf_q   <= 1'b0;
         dz_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         dmt_q   <= dmt_d;
         sgn_q   <= sgn_d;
         ld_q    <= ld_d;
         cr_q    <= cr_d;
         dm_q    <= dm_d;
         pm_q    <= pm_d;
         rcr_q   <= rcr_d;
         rdm_q   <= rdm_d;
         done_q  <= done_d;
         crwe_q  <= crwe_d;
         dmwe_q  <= dmwe_d;
         ovf_q   <= ovf_d;
         dz_q    <= dz_d;
      end
   end

endmodule

// File: doc/alu_mc.md
ALU_MC -- requirements
Module: alu_mc

Interface
REQ-001 Parameter DATA_W, default 32, datapath width; legal values 32 or 64.
REQ-002 Parameter OPC_W, default 8, instruction code width.
REQ-003 clk  in  1  single clock; all state changes on rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 start  in  1  request; accepted only when ready=1.
REQ-006 ready  out  1  high in IDLE.
REQ-007 instr_code  in  OPC_W  opcode from shared package.
REQ-008 dm_type  in  2  operand width: 00=BIT(1), 01=BYTE(8), 10=WORD(16), 11=DWORD(DATA_W).
REQ-009 sgn  in  1  1 = signed compare for GT/GE/LT/LE.
REQ-010 cr_in, dm_in, pm_const  in  DATA_W each  current result, data memory operand, program constant.
REQ-011 done  out  1  one-cycle pulse, results valid.
REQ-012 alu_out_cr, alu_out_dm  out  DATA_W each  registered results.
REQ-013 cr_we, dm_we  out  1 each  write enables, valid with done only.
REQ-014 ovf, div0  out  1 each  status flags, valid with done.

Function
REQ-015 Inputs captured into internal registers on the cycle start && ready; later input changes have no effect on the operation.
REQ-016 FSM states IDLE, EXEC, MUL, DIV, DONE; IDLE->EXEC for logic/load/store/trigger/compare/ADD/SUB, IDLE->MUL for MUL_I, IDLE->DIV for DIV_I/MOD_I, EXEC/MUL/DIV->DONE, DONE->IDLE.
REQ-017 Load, logic (incl. N and I variants), ST/STN, R/S, R_TRIG/F_TRIG, NOT, EQU: same semantics as the existing combinational ALU, computed in EXEC; done 2 cycles after accept.
REQ-018 Operands masked to dm_type width before every arithmetic/compare; results truncated to dm_type width and zero-extended to DATA_W.
REQ-019 ADD/SUB: ovf = carry out (ADD) or borrow (SUB) at dm_type width.
REQ-020 NE, GT, GE, LT, LE: alu_out_cr = {0..., flag}; signed compares use the dm_type MSB as sign when sgn=1; BIT type always unsigned.
REQ-021 MUL: unsigned shift-add, one bit per cycle, exactly DATA_W cycles in MUL regardless of dm_type; done DATA_W+2 cycles after accept; ovf = any nonzero product bit above dm_type width.
REQ-022 cr_we=1 for load/logic/arith/compare/trigger/NOT; dm_we=1 for ST/STN/R/S/trigger; both 0 for unknown opcode, which takes the EXEC path with zero results.
REQ-023 start while ready=0 ignored; no queuing.
REQ-024 done, cr_we, dm_we, ovf, div0 high only in DONE; results hold until next done.

Reset
REQ-025 rst_n low at any time, incl. mid-MUL/DIV: state IDLE, ready=1, all other outputs and internal registers 0, operation discarded without done.

Configuration
REQ-026 Macro ALU_MC_DIV_EN defined: DIV/MOD by unsigned restoring division, DATA_W cycles, done DATA_W+2 after accept; divisor 0 -> alu_out_cr=0, div0=1, done 2 cycles after accept.
REQ-027 ALU_MC_DIV_EN undefined: no divider logic; DIV/MOD take EXEC path, alu_out_cr=0, cr_we=0, div0=1.

Structure
REQ-028 Shared package alu_mc_pkg: all opcode constants (existing plus ADD_I, SUB_I, MUL_I, DIV_I, MOD_I, NE_I, GT_I, GE_I, LT_I, LE_I), dm_type encodings, FSM state encoding.
REQ-029 One sub-module alu_mc_seqdiv (iterative shift engine for MUL and DIV), instantiated once; body of DIV path guarded by ALU_MC_DIV_EN.

Verification
REQ-030 BYTE ADD cr_in=0xF0, dm_in=0x20 -> alu_out_cr=0x10, ovf=1, cr_we=1, done 2 cycles after accept.
REQ-031 WORD MUL 0x0100*0x0100 -> alu_out_cr=0, ovf=1, done at cycle 34 (DATA_W=32).
REQ-032 DWORD DIV 100/7 with ALU_MC_DIV_EN -> cr=14; MOD -> cr=2; divisor 0 -> cr=0, div0=1; without macro -> cr_we=0, div0=1.
REQ-033 BYTE GT sgn=1 cr=0x80, dm=0x01 -> cr=0; sgn=0 -> cr=1.
REQ-034 rst_n pulse low at cycle 10 of MUL -> no done, ready=1, outputs 0; next start runs normally.
REQ-035 start held high during busy MUL plus R_TRIG cr=1, dm=0 -> single done for MUL only; then cr=1, dm_out=1, dm_we=1.
